// File: rtl/sdram_arb2_if.sv
// Bundle of the two core-side request ports and the SDRAM controller strobe/ready side.
// slave: the arbiter's view; master: the environment (masters plus controller).
interface sdram_arb2_if;
  localparam int unsigned AW = 25;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 2;

  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0, din1;
  logic [BW-1:0] be0, be1;
  logic          ack0, ack1;
  logic [DW-1:0] dout0, dout1;

  logic [AW-1:0] sd_addr;
  logic [DW-1:0] sd_din;
  logic [BW-1:0] sd_wtbt;
  logic          sd_rd, sd_we;
  logic [DW-1:0] sd_dout;
  logic          sd_ready;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, din0, din1, be0, be1,
    output ack0, ack1, dout0, dout1,
    output sd_addr, sd_din, sd_wtbt, sd_rd, sd_we,
    input  sd_dout, sd_ready
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, din0, din1, be0, be1,
    input  ack0, ack1, dout0, dout1,
    input  sd_addr, sd_din, sd_wtbt, sd_rd, sd_we,
    output sd_dout, sd_ready
  );
endinterface

// File: rtl/sdram_arb2.sv
// Round-robin two-port requester in front of the edge-triggered SDRAM controller.
// One transaction at a time; hides strobe edges, the ready guard window and read hits.
module sdram_arb2 #(
  parameter int unsigned GUARD = 2
) (
  input  logic        clk,
  input  logic        reset,
  sdram_arb2_if.slave bus
);

  localparam int unsigned GW      = 3;
  localparam logic [GW-1:0] GUARD_L = GW'(GUARD);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

  state_t        state;
  logic [GW-1:0] gcnt;
  logic          last;

  logic          win_c;
  logic          we_c;
  logic [24:0]   addr_c;
  logic [15:0]   din_c;
  logic [1:0]    be_c;

  // Winner: a lone requester wins; on a tie the port that did not go last wins.
  always_comb begin
    win_c  = (bus.req0 && bus.req1) ? ~last : bus.req1;
    we_c   = win_c ? bus.we1   : bus.we0;
    addr_c = win_c ? bus.addr1 : bus.addr0;
    din_c  = win_c ? bus.din1  : bus.din0;
    be_c   = win_c ? bus.be1   : bus.be0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      gcnt        <= '0;
      last        <= 1'b1;
      bus.sd_rd   <= 1'b0;
      bus.sd_we   <= 1'b0;
      bus.ack0    <= 1'b0;
      bus.ack1    <= 1'b0;
      bus.sd_addr <= '0;
      bus.sd_din  <= '0;
      bus.sd_wtbt <= '0;
      bus.dout0   <= '0;
      bus.dout1   <= '0;
    end else begin
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      case (state)
        IDLE: begin
          // Ready low covers controller startup and work still in flight after a reset.
          if (bus.sd_ready && (bus.req0 || bus.req1)) begin
            bus.sd_addr <= addr_c;
            bus.sd_din  <= din_c;
            bus.sd_wtbt <= be_c;
            bus.sd_we   <= we_c;
            bus.sd_rd   <= ~we_c;
            last        <= win_c;
            gcnt        <= GUARD_L;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          // Ready is stale until the controller has reacted to the new edge.
          gcnt <= gcnt - GW'(1);
          if (gcnt <= GW'(1)) state <= WAIT;
        end
        WAIT: begin
          if (bus.sd_ready) begin
            bus.sd_rd <= 1'b0;
            bus.sd_we <= 1'b0;
            if (last) begin
              bus.ack1 <= 1'b1;
              if (bus.sd_rd) bus.dout1 <= bus.sd_dout;
            end else begin
              bus.ack0 <= 1'b1;
              if (bus.sd_rd) bus.dout0 <= bus.sd_dout;
            end
            state <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
